config_loader: RTL and testbench

Byte-stream configuration loader for the configurable fabric. Sits directly upstream of the `fpga` top: it accepts a framed bitstream over a valid/ready byte interface, checks it, and writes it frame-by-frame into the logic-tile and switch-box configuration registers (33-bit tile `mem`, 16-bit switch `configure`). It holds the fabric's `clear` low until a complete, checksum-clean bitstream has been written.

---
 rtl/config_loader_pkg.sv | 30 +++
 rtl/config_loader_if.sv | 15 +
 rtl/config_loader_frame_assembler.sv | 37 +++
 rtl/config_loader.sv | 113 +++++++++++
 tb/tb_config_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/config_loader_pkg.sv
// Shared constants and types for the fabric configuration loader.
// Frame address map: logic tiles occupy the low addresses, switch boxes follow.
package cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int FRAME_BYTES_DEF = 5;
  localparam int NUM_FRAMES_DEF  = 58;
  localparam int ADDR_W_DEF      = 6;

  localparam int NUM_TILES   = 17;
  localparam int NUM_SWITCH  = 41;
  localparam int TILE_BASE   = 0;
  localparam int SWITCH_BASE = TILE_BASE + NUM_TILES;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_COUNT,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Legal frame count: at least one frame, no more than the fabric holds.
  function automatic logic count_ok(input logic [7:0] n, input int max_frames);
    return (n != 8'd0) && (int'(n) <= max_frames);
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// Byte-stream input handshake plus the frame write bus towards the fabric.
interface config_loader_if #(
  parameter int FRAME_BYTES = 5,
  parameter int ADDR_W      = 6
);
  logic [7:0]               din;
  logic                     din_valid;
  logic                     din_ready;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [8*FRAME_BYTES-1:0] cfg_data;
  logic                     cfg_we;

  modport master (output din, din_valid, input din_ready, cfg_addr, cfg_data, cfg_we);
  modport slave  (input din, din_valid, output din_ready, cfg_addr, cfg_data, cfg_we);
endinterface

// File: rtl/config_loader_frame_assembler.sv
// Packs accepted bytes little-endian into one frame; o_frame is complete
// (combinationally, including the current byte) when o_last is high.
module cfg_frame_assembler #(
  parameter int FRAME_BYTES = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_vld,
  input  logic [7:0]               i_byte,
  output logic [8*FRAME_BYTES-1:0] o_frame,
  output logic                     o_last
);
  localparam int W     = 8 * FRAME_BYTES;
  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic [IDX_W-1:0] r_idx;
  logic [W-9:0]     r_sh;

  // Newest byte enters at the top so the first byte ends up in [7:0].
  assign o_frame = {i_byte, r_sh};
  assign o_last  = (r_idx == LAST_IDX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
      r_sh  <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_vld) begin
      r_sh  <= o_frame[W-1:8];
      r_idx <= o_last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Framed bitstream loader: hunts for sync, checks count, writes frames to the
// fabric and releases fabric reset only after a clean checksum.
module config_loader
  import cfg_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  config_loader_if.slave   bus,
  output logic             done,
  output logic             error,
  output logic             fabric_reset_n
);
  localparam int W = 8 * FRAME_BYTES;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_fidx, r_last;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_cfg_addr;
  logic [W-1:0]      r_cfg_data;
  logic              r_cfg_we;

  logic         w_ready, w_acc, w_ld_byte, w_clr, w_last, w_frame_done;
  logic [W-1:0] w_frame;

  assign w_acc        = bus.din_valid & w_ready;
  assign w_ld_byte    = w_acc && (r_state == ST_LOAD);
  assign w_clr        = w_acc && (r_state == ST_COUNT);
  assign w_frame_done = w_ld_byte & w_last;

  cfg_frame_assembler #(.FRAME_BYTES(FRAME_BYTES)) u_asm (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_vld   (w_ld_byte),
    .i_byte  (bus.din),
    .o_frame (w_frame),
    .o_last  (w_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_SYNC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SYNC:  if (w_acc && bus.din == SYNC_BYTE) w_next = ST_COUNT;
      ST_COUNT: if (w_acc) w_next = count_ok(bus.din, NUM_FRAMES) ? ST_LOAD : ST_ERROR;
      ST_LOAD:  if (w_frame_done && r_fidx == r_last) w_next = ST_CHECK;
      ST_CHECK: if (w_acc) w_next = (bus.din == r_csum) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR: if (restart) w_next = ST_SYNC;
      default:  w_next = ST_SYNC;
    endcase
  end

  always_comb begin
    w_ready        = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    fabric_reset_n = 1'b0;
    case (r_state)
      ST_DONE: begin
        w_ready        = 1'b0;
        done           = 1'b1;
        fabric_reset_n = 1'b1;
      end
      ST_ERROR: begin
        w_ready = 1'b0;
        error   = 1'b1;
      end
      default: ;
    endcase
  end

  // Frames go out before the checksum is known; the fabric stays in reset
  // until DONE, so a bad image never runs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fidx     <= '0;
      r_last     <= '0;
      r_csum     <= '0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_cfg_we   <= 1'b0;
    end else begin
      r_cfg_we <= w_frame_done;
      if (w_clr) begin
        r_fidx <= '0;
        r_last <= ADDR_W'(bus.din - 8'd1);
        r_csum <= '0;
      end
      if (w_ld_byte) r_csum <= r_csum ^ bus.din;
      if (w_frame_done) begin
        r_cfg_addr <= r_fidx;
        r_cfg_data <= w_frame;
        r_fidx     <= r_fidx + 1'b1;
      end
    end
  end

  assign bus.din_ready = w_ready;
  assign bus.cfg_addr  = r_cfg_addr;
  assign bus.cfg_data  = r_cfg_data;
  assign bus.cfg_we    = r_cfg_we;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: expected frame writes are queued as bytes
// are driven and matched against every cfg_we strobe.
module tb_config_loader;
  import cfg_pkg::*;

  localparam int FB = 5;
  localparam int NF = 58;
  localparam int AW = 6;
  localparam int W  = 8 * FB;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic restart = 1'b0;
  logic done, error, frn;

  config_loader_if #(.FRAME_BYTES(FB), .ADDR_W(AW)) bus ();

  config_loader #(.FRAME_BYTES(FB), .NUM_FRAMES(NF), .ADDR_W(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .restart        (restart),
    .bus            (bus),
    .done           (done),
    .error          (error),
    .fabric_reset_n (frn)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_we  = 0;
  logic [AW+W-1:0] sb[$];
  logic [W-1:0]    img[NF];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.cfg_we === 1'b1) begin
      n_we++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL we_unexpected: observed write addr %0d data %0h expected none",
               bus.cfg_addr, bus.cfg_data);
      end else begin
        logic [AW+W-1:0] e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.cfg_addr), 64'(e[AW+W-1:W]));
        chk("wr_data", 64'(bus.cfg_data), 64'(e[W-1:0]));
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      bus.din_valid = 1'b0;
      bus.din       = 8'($urandom);
      @(posedge clock); #1;
    end
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(posedge clock); #1;
    bus.din_valid = 1'b0;
  endtask

  // Everything up to (not including) the checksum byte; returns the checksum.
  task automatic send_image(input int n, input int maxgap, output logic [7:0] cs);
    logic [W-1:0] fr;
    logic [7:0]   b;
    cs = 8'h00;
    send(SYNC_BYTE, 0);
    send(8'(n), 0);
    for (int f = 0; f < n; f++) begin
      fr = img[f];
      sb.push_back({AW'(f), fr});
      for (int k = 0; k < FB; k++) begin
        b  = fr[8*k +: 8];
        cs = cs ^ b;
        send(b, (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
      end
    end
  endtask

  task automatic fill_img(input int n);
    for (int f = 0; f < n; f++) img[f] = W'({$urandom(), $urandom()});
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    64'(bus.cfg_we),    64'd0);
    chk({tag, "_addr"},  64'(bus.cfg_addr),  64'd0);
    chk({tag, "_data"},  64'(bus.cfg_data),  64'd0);
    chk({tag, "_done"},  64'(done),          64'd0);
    chk({tag, "_error"}, 64'(error),         64'd0);
    chk({tag, "_frn"},   64'(frn),           64'd0);
    chk({tag, "_ready"}, 64'(bus.din_ready), 64'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] cs;
    int we0;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;

    // Reset state
    #1;
    chk_reset_vals("rst");
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_rel_ready", 64'(bus.din_ready), 64'd1);

    // Full image, continuous valid: done rises right after the checksum edge
    fill_img(NF);
    we0 = n_we;
    send_image(NF, 0, cs);
    chk("full_done_early", 64'(done), 64'd0);
    send(cs, 0);
    chk("full_done", 64'(done), 64'd1);
    chk("full_frn", 64'(frn), 64'd1);
    chk("full_ready", 64'(bus.din_ready), 64'd0);
    settle();
    chk("full_we_cnt", 64'(n_we - we0), 64'd58);
    chk("full_sb", 64'(sb.size()), 64'd0);

    // Restart drops done/frn, raises ready
    pulse_restart();
    chk("rs_done", 64'(done), 64'd0);
    chk("rs_frn", 64'(frn), 64'd0);
    chk("rs_ready", 64'(bus.din_ready), 64'd1);

    // Leading garbage then N=2
    fill_img(2);
    we0 = n_we;
    send(8'h00, 0);
    send(8'h5A, 0);
    send_image(2, 0, cs);
    send(cs, 0);
    chk("garb_done", 64'(done), 64'd1);
    settle();
    chk("garb_we_cnt", 64'(n_we - we0), 64'd2);
    pulse_restart();

    // Illegal counts 0 and 59
    we0 = n_we;
    send(SYNC_BYTE, 0);
    send(8'd0, 0);
    chk("cnt0_error", 64'(error), 64'd1);
    chk("cnt0_ready", 64'(bus.din_ready), 64'd0);
    pulse_restart();
    chk("cnt0_rs_error", 64'(error), 64'd0);
    send(SYNC_BYTE, 0);
    send(8'd59, 0);
    chk("cnt59_error", 64'(error), 64'd1);
    chk("cnt59_ready", 64'(bus.din_ready), 64'd0);
    settle();
    chk("cnt_bad_we", 64'(n_we - we0), 64'd0);
    pulse_restart();

    // Boundary: N=58 accepted as a legal count is covered above; N=1 bad checksum,
    // with a restart pulse mid-load that must be ignored
    we0 = n_we;
    send(SYNC_BYTE, 0);
    send(8'd1, 0);
    pulse_restart();
    sb.push_back({AW'(0), 40'h0504030201});
    for (int k = 1; k <= 5; k++) send(8'(k), 0);
    send(8'h00, 0);
    chk("bad_cs_error", 64'(error), 64'd1);
    chk("bad_cs_frn", 64'(frn), 64'd0);
    chk("bad_cs_done", 64'(done), 64'd0);
    settle();
    chk("bad_cs_we_cnt", 64'(n_we - we0), 64'd1);
    pulse_restart();

    // Same frames gap-free then with random valid gaps
    fill_img(4);
    for (int pass = 0; pass < 2; pass++) begin
      we0 = n_we;
      send_image(4, pass * 3, cs);
      send(cs, pass * 2);
      chk("gap_done", 64'(done), 64'd1);
      settle();
      chk("gap_we_cnt", 64'(n_we - we0), 64'd4);
      chk("gap_sb", 64'(sb.size()), 64'd0);
      pulse_restart();
    end

    // Async reset after the 3rd frame byte, then a clean load
    we0 = n_we;
    send(SYNC_BYTE, 0);
    send(8'd3, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clock);
    reset = 1'b1;
    settle();
    chk("mid_no_we", 64'(n_we - we0), 64'd0);
    chk("mid_ready", 64'(bus.din_ready), 64'd1);
    fill_img(2);
    send_image(2, 1, cs);
    send(cs, 0);
    chk("post_rst_done", 64'(done), 64'd1);
    chk("post_rst_frn", 64'(frn), 64'd1);
    settle();
    chk("post_rst_we", 64'(n_we - we0), 64'd2);
    chk("post_rst_sb", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
